// File: rtl/mips_dmem_arbiter_pkg.sv
// Shared types and default widths for the mips data-memory path.
package mips_pkg;

  localparam int MIPS_ADDR_W = 10;
  localparam int MIPS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    DBG_RD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mips_dmem_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W
);

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mips_dmem_arbiter_starve_cnt.sv
// Saturating count of cycles a debug request has waited; flags when it reaches LIMIT.
// Only built with MIPS_DMEM_ARB_STARVE_GUARD_EN defined.
`ifdef MIPS_DMEM_ARB_STARVE_GUARD_EN
module mips_dmem_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic wait_i,
  input  logic clr_i,
  output logic starve_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (wait_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == CNT_W'(LIMIT));

endmodule
`endif

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port synchronous data memory between the core and a debug port.
// Define MIPS_DMEM_ARB_STARVE_GUARD_EN to let a long-waiting debug request pre-empt the core.
module mips_dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W
`ifdef MIPS_DMEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input logic                clock,
  input logic                reset,
  mips_dmem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              dbg_pend_s, starve_s, core_win_s, dbg_win_s;
  logic              mem_en_s, mem_we_s, core_stall_s, dbg_ack_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s, core_rdata_s;

  // In the read-ack cycle dbg_req still belongs to the request just served.
  assign dbg_pend_s = bus.dbg_req & ~rd_ack_q;

`ifdef MIPS_DMEM_ARB_STARVE_GUARD_EN
  mips_dmem_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock    (clock),
    .reset    (reset),
    .wait_i   (dbg_pend_s & ~dbg_win_s),
    .clr_i    (~dbg_pend_s | dbg_win_s),
    .starve_o (starve_s)
  );
`else
  assign starve_s = 1'b0;
`endif

  always_comb begin
    core_win_s = 1'b0;
    dbg_win_s  = 1'b0;
    if (state_q == IDLE) begin
      if (dbg_pend_s && (starve_s || !bus.core_req)) begin
        dbg_win_s = 1'b1;
      end else if (bus.core_req) begin
        core_win_s = 1'b1;
      end else begin
        core_win_s = 1'b0;
      end
    end else begin
      dbg_win_s = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ack_q    <= 1'b0;
      dbg_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_ack_q    <= rd_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ack_d    = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (core_win_s && !bus.core_we) begin
          state_d = CORE_RD;
        end else if (dbg_win_s && !bus.dbg_we) begin
          state_d = DBG_RD;
        end else begin
          state_d = IDLE;
        end
      end
      CORE_RD: state_d = IDLE;
      DBG_RD: begin
        state_d     = IDLE;
        rd_ack_d    = 1'b1;
        dbg_rdata_d = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant outputs are combinational, so they are forced quiet while reset is high.
  always_comb begin
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    core_stall_s = 1'b0;
    core_rdata_s = {DATA_W{1'b0}};
    dbg_ack_s    = rd_ack_q;
    if (reset) begin
      dbg_ack_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_win_s) begin
            mem_en_s     = 1'b1;
            mem_we_s     = bus.core_we;
            mem_addr_s   = bus.core_addr;
            mem_wdata_s  = bus.core_wdata;
            core_stall_s = ~bus.core_we;
          end else if (dbg_win_s) begin
            mem_en_s     = 1'b1;
            mem_we_s     = bus.dbg_we;
            mem_addr_s   = bus.dbg_addr;
            mem_wdata_s  = bus.dbg_wdata;
            dbg_ack_s    = bus.dbg_we;
            core_stall_s = bus.core_req;
          end else begin
            core_stall_s = 1'b0;
          end
        end
        CORE_RD: core_rdata_s = bus.mem_rdata;
        DBG_RD:  core_stall_s = bus.core_req;
        default: core_stall_s = 1'b0;
      endcase
    end
  end

  assign bus.mem_en     = mem_en_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.core_stall = core_stall_s;
  assign bus.core_rdata = core_rdata_s;
  assign bus.dbg_ack    = dbg_ack_s;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Bench for mips_dmem_arbiter: directed scenarios plus random traffic against a
// memory-port occupancy model; honours MIPS_DMEM_ARB_STARVE_GUARD_EN.
module tb_mips_dmem_arbiter;
  import mips_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;
`ifdef MIPS_DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD       = 1'b1;
  localparam int EXP_STARVE  = 4;
`else
  localparam bit GUARD       = 1'b0;
  localparam int EXP_STARVE  = 255;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  mips_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment RAM: one-cycle read latency, cleared by reset.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Reference model: tracks what the memory port is doing and who owns returning data.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            m_busy, m_ret_core, m_ack_due;
  logic [AW-1:0] m_ret_addr;
  logic [DW-1:0] m_dbg_rdata;
  int            m_wait;
  bit            last_stall, last_ack;

  always @(negedge clock) begin
    bit            live, force_dbg, core_go, dbg_go, crd_valid, n_busy, n_ret_core, n_ack;
    logic          e_en, e_we, e_stall, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_crd;
    last_stall = bus.core_stall;
    last_ack   = bus.dbg_ack;
    if (reset) begin
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_core_stall", bus.core_stall, 0);
      chk("rst_core_rdata", bus.core_rdata, 0);
      chk("rst_dbg_ack", bus.dbg_ack, 0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 0);
      m_busy = 0; m_ret_core = 0; m_ack_due = 0; m_wait = 0;
      m_ret_addr = '0; m_dbg_rdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      e_en = 0; e_we = 0; e_stall = 0; e_addr = '0; e_wd = '0; e_crd = '0;
      crd_valid = 0; n_busy = 0; n_ret_core = 0; n_ack = 0; core_go = 0; dbg_go = 0;
      e_ack     = m_ack_due;
      live      = bus.dbg_req && !m_ack_due;
      force_dbg = GUARD && (m_wait >= LIMIT);
      if (m_busy) begin
        if (m_ret_core) begin
          crd_valid = 1; e_crd = ref_mem[m_ret_addr];
        end else begin
          e_stall = bus.core_req; n_ack = 1;
        end
      end else if (live && (force_dbg || !bus.core_req)) dbg_go = 1;
      else if (bus.core_req) core_go = 1;
      if (core_go) begin
        e_en = 1; e_we = bus.core_we; e_addr = bus.core_addr; e_wd = bus.core_wdata;
        e_stall = !bus.core_we; n_busy = !bus.core_we; n_ret_core = 1;
      end
      if (dbg_go) begin
        e_en = 1; e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wd = bus.dbg_wdata;
        e_stall = bus.core_req; e_ack = bus.dbg_we; n_busy = !bus.dbg_we;
      end
      chk("mem_en", bus.mem_en, e_en);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("core_stall", bus.core_stall, e_stall);
      chk("dbg_ack", bus.dbg_ack, e_ack);
      if (m_ack_due) chk("dbg_rdata", bus.dbg_rdata, m_dbg_rdata);
      if (crd_valid) chk("core_rdata", bus.core_rdata, e_crd);
      if (e_en && e_we) ref_mem[e_addr] = e_wd;
      if (n_ack) m_dbg_rdata = ref_mem[m_ret_addr];
      m_wait = (live && !dbg_go) ? m_wait + 1 : 0;
      if (n_busy) m_ret_addr = e_addr;
      m_busy = n_busy; m_ret_core = n_ret_core; m_ack_due = n_ack;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  initial begin
    int first_ack;
    logic ack_stall;
    core_drive(1'b0, 1'b0, '0, '0);
    dbg_drive(1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    #2;
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_stall", bus.core_stall, 0);
    tick();
    reset = 1'b0;
    tick();

    // Core store then load of the same word.
    core_drive(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    #2;
    chk("st_mem_en", bus.mem_en, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_addr", bus.mem_addr, 5);
    chk("st_stall", bus.core_stall, 0);
    tick();
    core_drive(1'b1, 1'b0, 10'd5, 32'h0);
    #2;
    chk("ld_stall", bus.core_stall, 1);
    chk("ld_mem_we", bus.mem_we, 0);
    tick();
    #2;
    chk("ld_stall_done", bus.core_stall, 0);
    chk("ld_rdata", bus.core_rdata, 32'hDEADBEEF);
    chk("ld_mem_idle", bus.mem_en, 0);
    tick();
    core_drive(1'b0, 1'b0, '0, '0);

    // Debug write then debug read.
    dbg_drive(1'b1, 1'b1, 10'd3, 32'h12345678);
    #2;
    chk("dw_ack", bus.dbg_ack, 1);
    chk("dw_mem_we", bus.mem_we, 1);
    tick();
    dbg_drive(1'b1, 1'b0, 10'd3, 32'h0);
    #2;
    chk("dr_grant_ack", bus.dbg_ack, 0);
    chk("dr_grant_en", bus.mem_en, 1);
    tick();
    #2;
    chk("dr_wait_ack", bus.dbg_ack, 0);
    tick();
    #2;
    chk("dr_ack", bus.dbg_ack, 1);
    chk("dr_rdata", bus.dbg_rdata, 32'h12345678);
    tick();
    dbg_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Simultaneous core load and debug read: core first.
    core_drive(1'b1, 1'b0, 10'd5, 32'h0);
    dbg_drive(1'b1, 1'b0, 10'd3, 32'h0);
    #2;
    chk("both_stall", bus.core_stall, 1);
    chk("both_addr", bus.mem_addr, 5);
    tick();
    #2;
    chk("both_core_rdata", bus.core_rdata, 32'hDEADBEEF);
    chk("both_core_stall", bus.core_stall, 0);
    tick();
    core_drive(1'b0, 1'b0, '0, '0);
    #2;
    chk("both_dbg_grant", bus.mem_addr, 3);
    tick();
    tick();
    #2;
    chk("both_dbg_ack", bus.dbg_ack, 1);
    chk("both_dbg_rdata", bus.dbg_rdata, 32'h12345678);
    tick();
    dbg_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Core hammers loads while debug waits with a write.
    first_ack = 255;
    ack_stall = 1'b0;
    core_drive(1'b1, 1'b0, 10'd5, 32'h0);
    dbg_drive(1'b1, 1'b1, 10'd7, 32'hA5A5A5A5);
    for (int k = 0; k < 20; k++) begin
      #2;
      if (bus.dbg_ack && first_ack == 255) begin
        first_ack = k;
        ack_stall = bus.core_stall;
      end
      tick();
      if (first_ack != 255) bus.dbg_req = 1'b0;
    end
    chk("starve_ack_cycle", first_ack, EXP_STARVE);
`ifdef MIPS_DMEM_ARB_STARVE_GUARD_EN
    chk("starve_core_stall", ack_stall, 1);
`endif
    core_drive(1'b0, 1'b0, '0, '0);
    dbg_drive(1'b0, 1'b0, '0, '0);
    tick();

    // Asynchronous reset in the middle of a core load.
    core_drive(1'b1, 1'b0, 10'd5, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("arst_mem_en", bus.mem_en, 0);
    chk("arst_stall", bus.core_stall, 0);
    chk("arst_core_rdata", bus.core_rdata, 0);
    chk("arst_dbg_ack", bus.dbg_ack, 0);
    chk("arst_dbg_rdata", bus.dbg_rdata, 0);
    core_drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    #2;
    chk("post_rst_rdata", bus.core_rdata, 0);
    chk("post_rst_ack", bus.dbg_ack, 0);
    chk("post_rst_stall", bus.core_stall, 0);
    tick();

    // Random traffic obeying the hold-until-served protocol on both sides.
    for (int c = 0; c < 4000; c++) begin
      if (!bus.core_req || !last_stall)
        core_drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 15)), $urandom);
      if (!bus.dbg_req || last_ack)
        dbg_drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), $urandom);
      tick();
    end
    core_drive(1'b0, 1'b0, '0, '0);
    dbg_drive(1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
